// File: rtl/memoria_dados_resp.sv
// Data memory (256 x 8) with fixed-latency request/response handshake toward the core.
// One access in flight at a time; Pronto pulses once when the access completes.
module memoria_dados_resp #(
    parameter int LATENCIA = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] EndMemDados,
    input  logic [7:0] DadoEscritoMem,
    input  logic       EscMem,
    input  logic       LerMem,
    output logic [7:0] DadoLidoMem,
    output logic       Pronto,
    output logic       Ocupado,
    output logic       Erro,
    output logic [7:0] ContAcessos,
    output logic [1:0] o_estado_dbg
);

    // Handshake: in OCIOSO a single level-high request (LerMem xor EscMem) is taken at
    // the clock edge; the core must then wait for the one-cycle Pronto pulse. Requests
    // while Ocupado is high are dropped, and both requests high together flag Erro.

    localparam logic [2:0] LAT = 3'(LATENCIA);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ESPERA   = 2'd1,
        RESPOSTA = 2'd2
    } estado_t;

    estado_t    r_estado;
    estado_t    w_prox_estado;
    logic [2:0] r_cont;
    logic [7:0] r_end;
    logic [7:0] r_dado;
    logic       r_escrita;
    logic [7:0] r_mem [256];

    logic       w_aceita;
    logic       w_conflito;
    logic       w_conclui;

    always_comb begin
        w_aceita   = (r_estado == OCIOSO) && (LerMem ^ EscMem);
        w_conflito = (r_estado == OCIOSO) && LerMem && EscMem;
        w_conclui  = (r_estado == ESPERA) && (r_cont == 3'd1);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_prox_estado;
        end
    end

    always_comb begin
        w_prox_estado = r_estado;
        case (r_estado)
            OCIOSO:   if (w_aceita)  w_prox_estado = ESPERA;
            ESPERA:   if (w_conclui) w_prox_estado = RESPOSTA;
            RESPOSTA: w_prox_estado = OCIOSO;
            default:  w_prox_estado = OCIOSO;
        endcase
    end

    // Operands are captured at acceptance so the core may change its inputs freely afterwards.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_cont      <= 3'd0;
            r_end       <= 8'd0;
            r_dado      <= 8'd0;
            r_escrita   <= 1'b0;
            DadoLidoMem <= 8'd0;
            Pronto      <= 1'b0;
            Erro        <= 1'b0;
            ContAcessos <= 8'd0;
        end else begin
            Pronto <= w_conclui;
            if (w_aceita) begin
                r_cont    <= LAT;
                r_end     <= EndMemDados;
                r_dado    <= DadoEscritoMem;
                r_escrita <= EscMem;
            end else if (r_estado == ESPERA) begin
                r_cont <= r_cont - 3'd1;
            end
            if (w_conclui) begin
                ContAcessos <= ContAcessos + 8'd1;
                if (!r_escrita) begin
                    DadoLidoMem <= r_mem[r_end];
                end
            end
            if (w_conflito) begin
                Erro <= 1'b1;
            end
        end
    end

    // Array has no reset; a reset mid-access forces OCIOSO so the write never commits.
    always_ff @(posedge Clock) begin
        if (w_conclui && r_escrita) begin
            r_mem[r_end] <= r_dado;
        end
    end

    assign Ocupado      = (r_estado != OCIOSO);
    assign o_estado_dbg = r_estado;

endmodule

// File: tb/tb_memoria_dados_resp.sv
// Self-checking bench for memoria_dados_resp: directed steps plus randomized accesses
// compared against a transaction-level model of the memory and its counters.
module tb_memoria_dados_resp;

    localparam int L = 2;

    logic       Clock;
    logic       Reset;
    logic [7:0] EndMemDados;
    logic [7:0] DadoEscritoMem;
    logic       EscMem;
    logic       LerMem;
    logic [7:0] DadoLidoMem;
    logic       Pronto;
    logic       Ocupado;
    logic       Erro;
    logic [7:0] ContAcessos;
    logic [1:0] o_estado_dbg;

    memoria_dados_resp #(.LATENCIA(L)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .EndMemDados    (EndMemDados),
        .DadoEscritoMem (DadoEscritoMem),
        .EscMem         (EscMem),
        .LerMem         (LerMem),
        .DadoLidoMem    (DadoLidoMem),
        .Pronto         (Pronto),
        .Ocupado        (Ocupado),
        .Erro           (Erro),
        .ContAcessos    (ContAcessos),
        .o_estado_dbg   (o_estado_dbg)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference model: memory image, completed-access count, last read data, sticky error.
    logic [7:0] mem_m [256];
    logic [7:0] cnt_m;
    logic [7:0] dado_m;
    logic       erro_m;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_idle();
        LerMem = 1'b0;
        EscMem = 1'b0;
    endtask

    task automatic garbage(input logic [7:0] addr);
        EndMemDados    = addr;
        DadoEscritoMem = 8'($urandom);
        LerMem         = 1'($urandom_range(0, 1));
        EscMem         = 1'($urandom_range(0, 1));
    endtask

    task automatic check_status();
        chk8("cont", ContAcessos, cnt_m);
        chk8("dado", DadoLidoMem, dado_m);
        chk1("erro", Erro, erro_m);
    endtask

    // Called just after an edge with the block idle. Inputs are scrambled once the
    // request is taken to show they cannot disturb the access in flight.
    task automatic do_access(input bit wr, input logic [7:0] addr, input logic [7:0] data);
        EndMemDados    = addr;
        DadoEscritoMem = data;
        EscMem         = wr;
        LerMem         = !wr;
        tick();
        chk1("ocupado_aceite", Ocupado, 1'b1);
        chk1("pronto_aceite", Pronto, 1'b0);
        garbage(addr + 8'd1);
        for (int k = 1; k <= L; k++) begin
            tick();
            if (k < L) begin
                chk1("pronto_espera", Pronto, 1'b0);
                chk1("ocupado_espera", Ocupado, 1'b1);
                garbage(8'($urandom));
            end
        end
        cnt_m = cnt_m + 8'd1;
        if (wr) mem_m[addr] = data;
        else    dado_m = mem_m[addr];
        chk1("pronto_fim", Pronto, 1'b1);
        chk1("ocupado_fim", Ocupado, 1'b1);
        check_status();
        garbage(8'($urandom));
        tick();
        chk1("pronto_cai", Pronto, 1'b0);
        chk1("ocupado_livre", Ocupado, 1'b0);
        chk1("erro_busy", Erro, erro_m);
        set_idle();
    endtask

    // Pulse Reset between edges and check the asynchronous clear while it is high.
    task automatic pulse_reset();
        Reset = 1'b1;
        #1;
        cnt_m  = 8'd0;
        dado_m = 8'd0;
        erro_m = 1'b0;
        chk1("rst_pronto", Pronto, 1'b0);
        chk1("rst_ocupado", Ocupado, 1'b0);
        check_status();
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] prior;
        logic [7:0] a;
        int         p;

        Reset          = 1'b0;
        EndMemDados    = 8'd0;
        DadoEscritoMem = 8'd0;
        set_idle();
        cnt_m  = 8'd0;
        dado_m = 8'd0;
        erro_m = 1'b0;
        #2;
        pulse_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        check_status();

        // Write then read the same address; count reaches 2.
        do_access(1'b1, 8'h10, 8'hA5);
        do_access(1'b0, 8'h10, 8'h00);
        chk8("req030_dado", DadoLidoMem, 8'hA5);
        chk8("req030_cont", ContAcessos, 8'd2);

        // Address changed to 0x11 during the read's wait; data must still come from 0x10.
        do_access(1'b1, 8'h11, 8'h5A);
        do_access(1'b0, 8'h10, 8'h00);
        chk8("req035_dado", DadoLidoMem, 8'hA5);

        // Fill every location: 256 completions wrap the counter back to zero.
        tick();
        pulse_reset();
        for (int i = 0; i < 256; i++) begin
            a = 8'(i);
            do_access(1'b1, a, (a == 8'h20) ? 8'h77 : 8'($urandom));
        end
        chk8("cont_wrap", ContAcessos, 8'h00);

        // Read held high: one access per L+2 edges, Ocupado low one cycle in between.
        a = 8'($urandom);
        EndMemDados = a;
        LerMem      = 1'b1;
        p = L + 2;
        for (int k = 0; k < 3 * p; k++) begin
            tick();
            chk1("held_pronto", Pronto, (k % p) == L);
            chk1("held_ocupado", Ocupado, (k % p) != (L + 1));
        end
        set_idle();
        cnt_m  = cnt_m + 8'd3;
        dado_m = mem_m[a];
        check_status();

        // Randomized mix of reads and writes.
        for (int i = 0; i < 40; i++) begin
            do_access(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        end

        // Reset during the write's wait aborts it; the old contents survive.
        prior = mem_m[8'h20];
        EndMemDados    = 8'h20;
        DadoEscritoMem = 8'h3C;
        EscMem         = 1'b1;
        tick();
        set_idle();
        tick();
        chk1("abort_ocupado", Ocupado, 1'b1);
        pulse_reset();
        for (int k = 0; k < L + 2; k++) begin
            tick();
            chk1("abort_pronto", Pronto, 1'b0);
        end
        do_access(1'b0, 8'h20, 8'h00);
        chk8("abort_dado", DadoLidoMem, prior);

        // Both requests high in OCIOSO: sticky error, nothing accepted.
        LerMem      = 1'b1;
        EscMem      = 1'b1;
        EndMemDados = 8'h33;
        tick();
        erro_m = 1'b1;
        chk1("conf_erro", Erro, 1'b1);
        chk1("conf_ocupado", Ocupado, 1'b0);
        tick();
        chk1("conf_pronto", Pronto, 1'b0);
        chk1("conf_ocupado2", Ocupado, 1'b0);
        set_idle();
        tick();
        check_status();
        do_access(1'b0, 8'h10, 8'h00);
        chk1("erro_persiste", Erro, 1'b1);
        tick();
        pulse_reset();
        tick();
        chk1("erro_limpo", Erro, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
